bbox_engine: RTL and testbench

Parametrised bounding-box accelerator. Host loads a greyscale frame into an internal pixel RAM through a write port, then issues a start command. A raster scanner thresholds every pixel and reports the min/max x/y of all set pixels plus a found flag. It succeeds the fixed 100x100 single-threshold top level as the Avalon-facing compute block.

---
 rtl/bbox_pkg.sv | 30 +++
 rtl/bbox_pixel_ram.sv | 54 +++++
 rtl/bbox_engine.sv | 254 +++++++++++++++++++++++++
 tb/tb_bbox_engine.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bbox_pkg.sv
// -----------------------------------------------------------------------------
// bbox_pkg
// Shared types and constants for the bounding-box engine.
//   bbox_state_t  : scan controller states
//   BBOX_DEF_*    : default frame geometry and pixel width
//   bbox_max      : larger of two integers (coordinate width sizing)
//   bbox_addr_w   : pixel RAM address width for a given frame geometry
// -----------------------------------------------------------------------------
package bbox_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } bbox_state_t;

  localparam int BBOX_DEF_IMG_W = 100;
  localparam int BBOX_DEF_IMG_H = 100;
  localparam int BBOX_DEF_PIX_W = 8;

  function automatic int bbox_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int bbox_addr_w(input int w, input int h);
    return $clog2(w * h);
  endfunction

endpackage

// File: rtl/bbox_pixel_ram.sv
// -----------------------------------------------------------------------------
// bbox_pixel_ram
// Frame buffer: one write port, one synchronous read port (1-cycle latency).
// A read of the address being written in the same cycle returns the new data.
// Out-of-range write addresses are dropped. Contents are never reset.
// Ports:
//   clk_i      : clock
//   wr_en_i    : write strobe
//   wr_addr_i  : write address (linear pixel index)
//   wr_data_i  : write data
//   rd_addr_i  : read address
//   rd_data_o  : read data, valid one cycle after rd_addr_i
// -----------------------------------------------------------------------------
module bbox_pixel_ram
  import bbox_pkg::*;
#(
  parameter int DEPTH  = BBOX_DEF_IMG_W * BBOX_DEF_IMG_H,
  parameter int ADDR_W = bbox_addr_w(BBOX_DEF_IMG_W, BBOX_DEF_IMG_H),
  parameter int PIX_W  = BBOX_DEF_PIX_W
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [PIX_W-1:0]  wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [PIX_W-1:0]  rd_data_o
);

  logic [PIX_W-1:0] mem_q [DEPTH];
  logic [PIX_W-1:0] rd_data_q;
  logic             wr_ok_s;

  // Extra top bit so a depth equal to 2**ADDR_W is still representable.
  assign wr_ok_s = wr_en_i && ({1'b0, wr_addr_i} < (ADDR_W+1)'(DEPTH));

  // Storage write.
  always_ff @(posedge clk_i) begin
    if (wr_ok_s) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read with write-first bypass on an address collision.
  always_ff @(posedge clk_i) begin
    if (wr_ok_s && (wr_addr_i == rd_addr_i)) begin
      rd_data_q <= wr_data_i;
    end else begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/bbox_engine.sv
// -----------------------------------------------------------------------------
// bbox_engine
// Bounding-box accelerator. The host fills the pixel RAM, then pulses start.
// A raster scan thresholds every pixel (set when value >= threshold) and
// reports the min/max x/y of all set pixels plus a found flag.
// Optional build macro: BBOX_COUNT_EN adds pix_count, the number of set pixels.
// Ports:
//   CLOCK_50          : clock, rising edge
//   reset             : asynchronous active-high reset
//   wr_en/wr_addr/wr_data : pixel write port (ignored while busy)
//   start             : scan request strobe (ignored while busy)
//   threshold         : pixel threshold, sampled at start
//   busy              : scan in progress
//   done              : one-cycle pulse when results are updated
//   found             : at least one set pixel in the last scan
//   x_min/x_max/y_min/y_max : bounding box of the last scan (0 when empty)
//   pix_count         : set-pixel count of the last scan (BBOX_COUNT_EN only)
// -----------------------------------------------------------------------------
module bbox_engine
  import bbox_pkg::*;
#(
  parameter int IMG_W   = BBOX_DEF_IMG_W,
  parameter int IMG_H   = BBOX_DEF_IMG_H,
  parameter int PIX_W   = BBOX_DEF_PIX_W,
  parameter int COORD_W = $clog2(bbox_max(IMG_W, IMG_H)),
  parameter int ADDR_W  = bbox_addr_w(IMG_W, IMG_H)
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [PIX_W-1:0]   wr_data,
  input  logic               start,
  input  logic [PIX_W-1:0]   threshold,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [COORD_W-1:0] x_min,
  output logic [COORD_W-1:0] x_max,
  output logic [COORD_W-1:0] y_min,
  output logic [COORD_W-1:0] y_max
`ifdef BBOX_COUNT_EN
  ,
  output logic [ADDR_W:0]    pix_count
`endif
);

  localparam int N = IMG_W * IMG_H;

  bbox_state_t state_q, state_d;

  logic               clear_s;   // accept a start: latch threshold, reset accumulators
  logic               adv_s;     // issue one read and step the raster counters
  logic               fin_s;     // publish results
  logic               last_s;
  logic               set_s;

  logic               busy_q, done_q, found_q;
  logic [COORD_W-1:0] x_min_q, x_max_q, y_min_q, y_max_q;

  logic [PIX_W-1:0]   thr_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [COORD_W-1:0] x_q, y_q;
  logic [COORD_W-1:0] xp_q, yp_q;   // coordinates of the pixel now on rd_data_s
  logic               vld_q;        // rd_data_s belongs to this scan
  logic [PIX_W-1:0]   rd_data_s;

  logic               hit_q;
  logic [COORD_W-1:0] run_xmin_q, run_xmax_q, run_ymin_q, run_ymax_q;

  bbox_pixel_ram #(
    .DEPTH  (N),
    .ADDR_W (ADDR_W),
    .PIX_W  (PIX_W)
  ) u_ram (
    .clk_i     (CLOCK_50),
    .wr_en_i   (wr_en && !busy_q),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_addr_i (addr_q),
    .rd_data_o (rd_data_s)
  );

  assign last_s = (addr_q == ADDR_W'(N - 1));
  assign set_s  = vld_q && (rd_data_s >= thr_q);

  // Controller state register.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state control strobes.
  always_comb begin
    state_d = state_q;
    clear_s = 1'b0;
    adv_s   = 1'b0;
    fin_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          clear_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        adv_s = 1'b1;
        if (last_s) begin
          state_d = DRAIN;
        end else begin
          state_d = SCAN;
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      DONE: begin
        fin_s   = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read address and raster x/y counters; x wraps, y steps on the wrap.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      thr_q  <= {PIX_W{1'b0}};
      addr_q <= {ADDR_W{1'b0}};
      x_q    <= {COORD_W{1'b0}};
      y_q    <= {COORD_W{1'b0}};
    end else if (clear_s) begin
      thr_q  <= threshold;
      addr_q <= {ADDR_W{1'b0}};
      x_q    <= {COORD_W{1'b0}};
      y_q    <= {COORD_W{1'b0}};
    end else if (adv_s) begin
      addr_q <= addr_q + ADDR_W'(1);
      if (x_q == COORD_W'(IMG_W - 1)) begin
        x_q <= {COORD_W{1'b0}};
        y_q <= y_q + COORD_W'(1);
      end else begin
        x_q <= x_q + COORD_W'(1);
      end
    end
  end

  // One-cycle delayed coordinates, aligned with the RAM read latency.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      vld_q <= 1'b0;
      xp_q  <= {COORD_W{1'b0}};
      yp_q  <= {COORD_W{1'b0}};
    end else begin
      vld_q <= adv_s;
      xp_q  <= x_q;
      yp_q  <= y_q;
    end
  end

  // Running bounding box over the set pixels of the current scan.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      hit_q      <= 1'b0;
      run_xmin_q <= {COORD_W{1'b1}};
      run_xmax_q <= {COORD_W{1'b0}};
      run_ymin_q <= {COORD_W{1'b1}};
      run_ymax_q <= {COORD_W{1'b0}};
    end else if (clear_s) begin
      hit_q      <= 1'b0;
      run_xmin_q <= {COORD_W{1'b1}};
      run_xmax_q <= {COORD_W{1'b0}};
      run_ymin_q <= {COORD_W{1'b1}};
      run_ymax_q <= {COORD_W{1'b0}};
    end else if (set_s) begin
      hit_q <= 1'b1;
      if (xp_q < run_xmin_q) run_xmin_q <= xp_q;
      if (xp_q > run_xmax_q) run_xmax_q <= xp_q;
      if (yp_q < run_ymin_q) run_ymin_q <= yp_q;
      if (yp_q > run_ymax_q) run_ymax_q <= yp_q;
    end
  end

  // Busy flag: raised on an accepted start, dropped as results publish.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
    end else if (clear_s) begin
      busy_q <= 1'b1;
    end else if (fin_s) begin
      busy_q <= 1'b0;
    end
  end

  // Result registers; an empty scan reports an all-zero box.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      done_q  <= 1'b0;
      found_q <= 1'b0;
      x_min_q <= {COORD_W{1'b0}};
      x_max_q <= {COORD_W{1'b0}};
      y_min_q <= {COORD_W{1'b0}};
      y_max_q <= {COORD_W{1'b0}};
    end else begin
      done_q <= fin_s;
      if (fin_s) begin
        found_q <= hit_q;
        x_min_q <= hit_q ? run_xmin_q : {COORD_W{1'b0}};
        x_max_q <= hit_q ? run_xmax_q : {COORD_W{1'b0}};
        y_min_q <= hit_q ? run_ymin_q : {COORD_W{1'b0}};
        y_max_q <= hit_q ? run_ymax_q : {COORD_W{1'b0}};
      end
    end
  end

`ifdef BBOX_COUNT_EN
  logic [ADDR_W:0] cnt_q, pix_count_q;

  // Set-pixel counter and its published copy.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cnt_q       <= {(ADDR_W+1){1'b0}};
      pix_count_q <= {(ADDR_W+1){1'b0}};
    end else begin
      if (clear_s) begin
        cnt_q <= {(ADDR_W+1){1'b0}};
      end else if (set_s) begin
        cnt_q <= cnt_q + (ADDR_W+1)'(1);
      end
      if (fin_s) begin
        pix_count_q <= cnt_q;
      end
    end
  end

  assign pix_count = pix_count_q;
`endif

  assign busy  = busy_q;
  assign done  = done_q;
  assign found = found_q;
  assign x_min = x_min_q;
  assign x_max = x_max_q;
  assign y_min = y_min_q;
  assign y_max = y_max_q;

endmodule

// File: tb/tb_bbox_engine.sv
// -----------------------------------------------------------------------------
// tb_bbox_engine
// Self-checking bench for bbox_engine on an 8x4 frame: a table of directed
// frames/thresholds with hand-computed boxes, hand-written sequences for
// mid-scan interference, write-first start and reset during a scan, and
// random sparse frames compared against a direct frame-walking model.
// -----------------------------------------------------------------------------
module tb_bbox_engine;

  localparam int W = 8;
  localparam int H = 4;
  localparam int N = W * H;

  logic       clk;
  logic       reset;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       start;
  logic [7:0] threshold;
  logic       busy, done, found;
  logic [2:0] x_min, x_max, y_min, y_max;
`ifdef BBOX_COUNT_EN
  logic [5:0] pix_count;
`endif

  bbox_engine #(
    .IMG_W (W),
    .IMG_H (H),
    .PIX_W (8)
  ) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .threshold (threshold),
    .busy      (busy),
    .done      (done),
    .found     (found),
    .x_min     (x_min),
    .x_max     (x_max),
    .y_min     (y_min),
    .y_max     (y_max)
`ifdef BBOX_COUNT_EN
    ,
    .pix_count (pix_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int setup;
    int thr;
    int f;
    int xmn;
    int xmx;
    int ymn;
    int ymx;
    int cnt;
  } vec_t;

  vec_t vecs[5];
  int   frame[N];
  int   checks   = 0;
  int   failures = 0;
  int   lat;
  int   mf, mxmn, mxmx, mymn, mymx, mcnt;
  int   extra;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_box(input string tag, input int f, input int xmn, input int xmx,
                           input int ymn, input int ymx, input int cnt);
    check({tag, ".found"}, int'(found), f);
    check({tag, ".x_min"}, int'(x_min), xmn);
    check({tag, ".x_max"}, int'(x_max), xmx);
    check({tag, ".y_min"}, int'(y_min), ymn);
    check({tag, ".y_max"}, int'(y_max), ymx);
`ifdef BBOX_COUNT_EN
    check({tag, ".count"}, int'(pix_count), cnt);
`else
    if (cnt < 0) $display("negative count expectation in %s", tag);
`endif
  endtask

  // Reference: walk the frame row by row and collect the box of set pixels.
  task automatic model(input int thr, output int f, output int xmn, output int xmx,
                       output int ymn, output int ymx, output int cnt);
    f = 0; cnt = 0; xmn = W; xmx = -1; ymn = H; ymx = -1;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (frame[y * W + x] >= thr) begin
          f = 1;
          cnt++;
          if (x < xmn) xmn = x;
          if (x > xmx) xmx = x;
          if (y < ymn) ymn = y;
          if (y > ymx) ymx = y;
        end
      end
    end
    if (f == 0) begin
      xmn = 0; xmx = 0; ymn = 0; ymx = 0;
    end
  endtask

  // All tasks below start and end just after a falling edge.
  task automatic write_pix(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = a[4:0];
    wr_data = d[7:0];
    @(negedge clk);
    wr_en = 1'b0;
    frame[a] = d;
  endtask

  task automatic load_setup(input int s);
    for (int i = 0; i < N; i++) write_pix(i, 0);
    if (s == 0) begin
      write_pix(1 * W + 2, 200);
      write_pix(3 * W + 5, 200);
    end else if (s == 2) begin
      write_pix(31, 255);
    end
  endtask

  // Start a scan and wait for done. poke_at >= 0 injects a start + write to
  // index 0 mid-scan; start_wr writes 255 to index 0 together with start.
  task automatic run_scan(input int thr, input int poke_at, input bit start_wr,
                          output int l);
    bit got;
    threshold = thr[7:0];
    start     = 1'b1;
    if (start_wr) begin
      wr_en   = 1'b1;
      wr_addr = 5'd0;
      wr_data = 8'd255;
      frame[0] = 255;
    end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b0;
    check("busy_during_scan", int'(busy), 1);
    l   = 0;
    got = 1'b0;
    while (!got && l < 200) begin
      if (l == poke_at) begin
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 5'd0;
        wr_data = 8'd255;
      end
      @(posedge clk);
      l++;
      @(negedge clk);
      start = 1'b0;
      wr_en = 1'b0;
      if (done) got = 1'b1;
    end
    check("done_latency", l, N + 2);
  endtask

  initial begin
    vecs[0] = '{0, 128, 1, 2, 5, 1, 3, 2};
    vecs[1] = '{1, 1,   0, 0, 0, 0, 0, 0};
    vecs[2] = '{0, 0,   1, 0, 7, 0, 3, 32};
    vecs[3] = '{0, 201, 0, 0, 0, 0, 0, 0};
    vecs[4] = '{2, 255, 1, 7, 7, 3, 3, 1};

    reset = 1'b1; wr_en = 1'b0; wr_addr = 5'd0; wr_data = 8'd0;
    start = 1'b0; threshold = 8'd0;
    repeat (3) @(negedge clk);
    check("reset.busy", int'(busy), 0);
    check("reset.done", int'(done), 0);
    check_box("reset", 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    @(negedge clk);

    // Directed table.
    for (int v = 0; v < 5; v++) begin
      load_setup(vecs[v].setup);
      run_scan(vecs[v].thr, -1, 1'b0, lat);
      check_box($sformatf("vec%0d", v), vecs[v].f, vecs[v].xmn, vecs[v].xmx,
                vecs[v].ymn, vecs[v].ymx, vecs[v].cnt);
      @(negedge clk);
      check("done_one_cycle", int'(done), 0);
      check("busy_after_done", int'(busy), 0);
    end

    // Reset in the middle of a scan (previous box is 7,7,3,3).
    threshold = 8'd255;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset.busy", int'(busy), 0);
    check("midreset.done", int'(done), 0);
    check_box("midreset", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    extra = 0;
    repeat (50) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("midreset.no_done", extra, 0);
    run_scan(255, -1, 1'b0, lat);
    model(255, mf, mxmn, mxmx, mymn, mymx, mcnt);
    check_box("after_reset", mf, mxmn, mxmx, mymn, mymx, mcnt);

    // Start and write mid-scan are both ignored.
    load_setup(0);
    run_scan(128, 5, 1'b0, lat);
    check_box("poke", 1, 2, 5, 1, 3, 2);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) extra++;
    end
    check("poke.single_done", extra, 0);
    check("poke.hold_x_min", int'(x_min), 2);
    run_scan(128, -1, 1'b0, lat);
    check_box("rescan_ram0", 1, 2, 5, 1, 3, 2);

    // Write and start in the same cycle: the scan sees the new pixel 0.
    run_scan(255, -1, 1'b1, lat);
    model(255, mf, mxmn, mxmx, mymn, mymx, mcnt);
    check_box("write_first", mf, mxmn, mxmx, mymn, mymx, mcnt);

    // Random sparse frames against the model.
    for (int it = 0; it < 10; it++) begin
      for (int i = 0; i < N; i++) begin
        write_pix(i, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : 0);
      end
      mcnt = (it == 3) ? 0 : int'($urandom_range(1, 255));
      run_scan(mcnt, -1, 1'b0, lat);
      model(mcnt, mf, mxmn, mxmx, mymn, mymx, mcnt);
      check_box($sformatf("rand%0d", it), mf, mxmn, mxmx, mymn, mymx, mcnt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
